// File: rtl/pipe_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: merges stall requests, turns MEM
// exceptions into a one-cycle flush + redirect, and watches data-bus waits.
// Optional performance counters are built when PIPE_CTRL_PERF_EN is defined.
module pipe_ctrl #(
   parameter logic [31:0] EXC_VECTOR = 32'h0000_0020,
   parameter int          TIMEOUT    = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stallreq_if,
   input  logic        stallreq_id,
   input  logic        stallreq_ex,
   input  logic        stallreq_mem,
   input  logic [31:0] mem_exc,
   input  logic [31:0] cp0_epc,
   output logic [5:0]  stall,
   output logic        flush,
   output logic [31:0] new_pc,
   output logic        bus_timeout,
   output logic [31:0] stall_cycles,
   output logic [31:0] flush_count,
   output logic        state_dbg
);

   // stall[i]=1 freezes pipeline register i; no handshake, the vector is level-sensitive.
   typedef enum logic {RUN = 1'b0, FLUSHED = 1'b1} state_t;

   localparam logic [31:0] EXC_ERET = 32'h0000_000e;
   localparam logic [15:0] WD_LAST  = 16'(TIMEOUT - 1);

   state_t      state, state_nx;
   logic [15:0] wd_cnt;
   logic        wd_inc;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= RUN;
      else      state <= state_nx;
   end

   // Outputs are forced low while reset is held so they clear without an edge.
   always_comb begin
      state_nx = state;
      stall    = 6'b000000;
      flush    = 1'b0;
      new_pc   = 32'h0;
      if (rst) begin
         case (state)
            RUN: begin
               if (mem_exc != 32'h0) begin
                  flush    = 1'b1;
                  new_pc   = (mem_exc == EXC_ERET) ? cp0_epc : EXC_VECTOR;
                  state_nx = FLUSHED;
               end else if (stallreq_mem) stall = 6'b011111;
               else if (stallreq_ex)      stall = 6'b001111;
               else if (stallreq_id)      stall = 6'b000111;
               else if (stallreq_if)      stall = 6'b000011;
            end
            FLUSHED: begin
               if (stallreq_if) stall = 6'b000011;
               state_nx = RUN;
            end
            default: state_nx = RUN;
         endcase
      end
   end

   assign state_dbg = (state == FLUSHED);
   assign wd_inc    = (state == RUN) && stallreq_mem && (mem_exc == 32'h0);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wd_cnt      <= 16'h0;
         bus_timeout <= 1'b0;
      end else if (wd_inc) begin
         if (wd_cnt == WD_LAST) begin
            wd_cnt      <= 16'h0;
            bus_timeout <= 1'b1;
         end else begin
            wd_cnt      <= wd_cnt + 16'h1;
            bus_timeout <= 1'b0;
         end
      end else begin
         wd_cnt      <= 16'h0;
         bus_timeout <= 1'b0;
      end
   end

`ifdef PIPE_CTRL_PERF_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stall_cycles <= 32'h0;
         flush_count  <= 32'h0;
      end else begin
         if (stall != 6'b000000) stall_cycles <= stall_cycles + 32'h1;
         if (flush)              flush_count  <= flush_count + 32'h1;
      end
   end
`else
   assign stall_cycles = 32'h0;
   assign flush_count  = 32'h0;
`endif

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage MIPS pipeline.
- Merges per-stage stall requests into the 6-bit stall vector consumed by every pipeline register: PC, IF/ID, ID/EX, EX/MEM, MEM/WB.
- Turns the MEM-stage exception word into a one-cycle flush plus a redirect PC.
- Watches MEM-stage bus waits and raises a timeout pulse toward CP0.

Parameters:
- EXC_VECTOR, 32'h0000_0020, redirect PC for every exception except ERET.
- TIMEOUT, 16, consecutive stallreq_mem cycles before bus_timeout fires; legal range 2..65535.

Ports:
- clk  in  1  system clock, all state updates on posedge.
- rst  in  1  asynchronous, active-low reset; rst==0 resets immediately, independent of clk.
- stallreq_if  in  1  IF waiting on instruction bus.
- stallreq_id  in  1  ID load-use hazard.
- stallreq_ex  in  1  EX multi-cycle op (div/madd) busy.
- stallreq_mem  in  1  MEM waiting on data bus.
- mem_exc  in  32  exception type from EX/MEM; 0 = none, 32'h0000_000e = ERET, any other nonzero value = exception.
- cp0_epc  in  32  current EPC from CP0.
- stall  out  6  [0]=PC [1]=IF [2]=ID [3]=EX [4]=MEM [5]=WB; 1 = STOP.
- flush  out  1  clear all pipeline registers this cycle.
- new_pc  out  32  PC to load when flush=1.
- bus_timeout  out  1  one-cycle pulse to CP0.
- stall_cycles  out  32  performance counter (optional feature).
- flush_count  out  32  performance counter (optional feature).

Behaviour:
- FSM states: RUN, FLUSHED. Reset state is RUN.
- Reset values: stall=0, flush=0, new_pc=0, bus_timeout=0, wd_cnt=0, counters=0.
- stall, flush and new_pc are combinational from the current state and inputs. Zero-cycle latency is required so the flush hits the same edge on which the faulting instruction sits in EX/MEM.
- RUN, mem_exc != 0 (highest priority):
  - flush=1, stall=6'b000000.
  - new_pc = cp0_epc if mem_exc==32'h0e, else EXC_VECTOR.
  - Next state FLUSHED. All stall requests are ignored this cycle.
- RUN, mem_exc == 0: flush=0, new_pc=0, and stall is the highest requester:
  - mem -> 6'b011111
  - else ex -> 6'b001111
  - else id -> 6'b000111
  - else if -> 6'b000011
  - else 6'b000000
- FLUSHED, exactly one cycle:
  - mem_exc, stallreq_id, stallreq_ex and stallreq_mem are ignored, since the flushed pipeline holds bubbles.
  - stall = 6'b000011 if stallreq_if, else 0. flush=0.
  - Next state RUN unconditionally.
- Watchdog wd_cnt (16 bits):
  - Increments every cycle the state is RUN, stallreq_mem=1 and mem_exc==0.
  - Clears to 0 otherwise.
  - When wd_cnt == TIMEOUT-1 on an incrementing cycle: bus_timeout=1 next cycle (registered pulse), and wd_cnt wraps to 0.
  - A held request therefore pulses every TIMEOUT cycles.
- Simultaneous events:
  - Exception with stallreq_mem=1: the flush wins and wd_cnt clears.
  - bus_timeout never asserts in the cycle after a flush.
- Reset asserted mid-flush: the FSM returns to RUN asynchronously and all outputs go to their reset values at once.

Optional Feature:
- Macro: PIPE_CTRL_PERF_EN.
- Defined:
  - stall_cycles increments on every posedge where stall != 0.
  - flush_count increments on every posedge where flush=1.
  - Both are 32-bit, wrap from 32'hFFFF_FFFF to 0, and clear on reset.
- Undefined: both ports are tied to 32'h0 and no counter flops exist.

Test Plan:
- Stimulus: stallreq_id=1 and stallreq_ex=1 together, mem_exc=0. Required: stall=6'b001111, flush=0; after release, stall=0.
- Stimulus: mem_exc=32'h8 (syscall) for one cycle while stallreq_mem=1. Required: that cycle flush=1, new_pc=32'h20, stall=0; next cycle flush=0, state FLUSHED; the cycle after, back to RUN.
- Stimulus: mem_exc=32'h0e, cp0_epc=32'h0000_1234. Required: flush=1, new_pc=32'h1234; exception presented again during FLUSHED is ignored (flush=0).
- Stimulus: stallreq_mem held 40 cycles, TIMEOUT=16. Required: bus_timeout pulses exactly twice, on the cycles following the 16th and 32nd stalled cycles; stall=6'b011111 throughout.
- Stimulus: rst driven low between clock edges during FLUSHED with stallreq_if=1. Required: all outputs 0 immediately, without waiting for an edge.
- Stimulus, PIPE_CTRL_PERF_EN defined: 5 stalled cycles and 2 exceptions. Required: stall_cycles=5, flush_count=2. With the macro undefined, both read 0.
